// File: rtl/arbitro_escrita_banco.sv
// arbitro_escrita_banco
// Shares the single write port of the 8x8 register bank between the ULA
// result path (A) and the memory-load path (B). Each requester has a
// one-entry buffer. Selection is round-robin, except that two buffered
// writes to the same register issue oldest first. A pending-write mask and a
// decode stall are derived from the buffers and the issue register.
module arbitro_escrita_banco #(
  parameter int NREG = 8,
  parameter int LARG = 8,
  localparam int IW  = $clog2(NREG)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            ReqA,
  input  logic [IW-1:0]   RegA,
  input  logic [LARG-1:0] DadoA,
  output logic            AckA,
  input  logic            ReqB,
  input  logic [IW-1:0]   RegB,
  input  logic [LARG-1:0] DadoB,
  output logic            AckB,
  output logic            RegWrite,
  output logic [IW-1:0]   RegEscr,
  output logic [LARG-1:0] DadoEscr,
  input  logic [IW-1:0]   RegLido1,
  input  logic [IW-1:0]   RegLido2,
  output logic [NREG-1:0] Pendente,
  output logic            Bolha
);

  typedef enum logic {LADO_A = 1'b0, LADO_B = 1'b1} lado_t;

  logic            cheio_a, cheio_b;
  logic [IW-1:0]   reg_a, reg_b;
  logic [LARG-1:0] dado_a, dado_b;
  lado_t           vez;
  lado_t           mais_antigo;

  logic sel_a, sel_b;
  logic aceita_a, aceita_b;

  // Pick the buffer that owns the write port next: a lone full buffer wins,
  // a same-register pair goes by age, and otherwise the round-robin pointer decides.
  always_comb begin
    sel_a = cheio_a;
    if (cheio_a && cheio_b) begin
      if (reg_a == reg_b) sel_a = (mais_antigo == LADO_A);
      else                sel_a = (vez == LADO_A);
    end
    sel_b = cheio_b && !sel_a;
  end

  assign AckA     = !cheio_a || sel_a;
  assign AckB     = !cheio_b || sel_b;
  assign aceita_a = ReqA && AckA;
  assign aceita_b = ReqB && AckB;

  // Buffers, age, round-robin pointer and issue register.
  // A buffer that drains and reloads at the same edge stays full.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cheio_a     <= 1'b0;
      cheio_b     <= 1'b0;
      reg_a       <= '0;
      reg_b       <= '0;
      dado_a      <= '0;
      dado_b      <= '0;
      vez         <= LADO_A;
      mais_antigo <= LADO_A;
      RegWrite    <= 1'b0;
      RegEscr     <= '0;
      DadoEscr    <= '0;
    end else begin
      if (aceita_a) begin
        cheio_a <= 1'b1;
        reg_a   <= RegA;
        dado_a  <= DadoA;
      end else if (sel_a) begin
        cheio_a <= 1'b0;
      end

      if (aceita_b) begin
        cheio_b <= 1'b1;
        reg_b   <= RegB;
        dado_b  <= DadoB;
      end else if (sel_b) begin
        cheio_b <= 1'b0;
      end

      if (aceita_a && aceita_b)                   mais_antigo <= LADO_A;
      else if (aceita_a && cheio_b && !sel_b)     mais_antigo <= LADO_B;
      else if (aceita_b && cheio_a && !sel_a)     mais_antigo <= LADO_A;

      if (sel_a) begin
        vez      <= LADO_B;
        RegWrite <= 1'b1;
        RegEscr  <= reg_a;
        DadoEscr <= dado_a;
      end else if (sel_b) begin
        vez      <= LADO_A;
        RegWrite <= 1'b1;
        RegEscr  <= reg_b;
        DadoEscr <= dado_b;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  // A register is pending while it sits in either buffer or is being written this cycle.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      Pendente[r] = (cheio_a && (reg_a == IW'(r))) ||
                    (cheio_b && (reg_b == IW'(r))) ||
                    (RegWrite && (RegEscr == IW'(r)));
    end
  end

  assign Bolha = Pendente[RegLido1] | Pendente[RegLido2];

endmodule
